// File: rtl/mem_responder_if.sv
// Request/response channel between the core's memory port and mem_responder.
interface mem_responder_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [SIZE_W-1:0] req_size;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_abort;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_abort
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_abort
    );
endinterface

// File: rtl/mem_responder.sv
// Handshaked, size-aware memory endpoint: one request at a time, programmable
// wait states, little-endian byte/halfword/word access to a word-organised RAM.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH  = 1 << IDX_W;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              accept_c;

    logic              write_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              abort_c;
    logic [IDX_W-1:0]  idx_c;
    logic [1:0]        off_c;
    logic [DATA_W-1:0] word_c;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] wlane_c;
    logic [3:0]        be_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // A WAIT state with an exhausted counter cannot occur legally; it falls back to IDLE.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        accept_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_c = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lane steering for stores and lane extraction / rotation for loads.
    always_comb begin
        abort_c = (|(addr_q >> ADDR_WIDTH)) || (size_q == 2'b11);
        idx_c   = addr_q[ADDR_WIDTH-1:2];
        off_c   = addr_q[1:0];
        word_c  = mem[idx_c];
        be_c    = 4'b0000;
        wlane_c = wdata_q;
        load_c  = '0;
        case (size_q)
            2'b00: begin
                be_c    = 4'b0001 << off_c;
                wlane_c = {4{wdata_q[7:0]}};
                load_c  = {24'd0, word_c[8*off_c +: 8]};
            end
            2'b01: begin
                be_c    = off_c[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{wdata_q[15:0]}};
                load_c  = {16'd0, (off_c[1] ? word_c[31:16] : word_c[15:0])};
            end
            2'b10: begin
                be_c = 4'b1111;
                case (off_c)
                    2'd0:    load_c = word_c;
                    2'd1:    load_c = {word_c[7:0],  word_c[31:8]};
                    2'd2:    load_c = {word_c[15:0], word_c[31:16]};
                    default: load_c = {word_c[23:0], word_c[31:24]};
                endcase
            end
            default: begin
                be_c   = 4'b0000;
                load_c = '0;
            end
        endcase
    end

    // Request capture and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q       <= 1'b0;
            size_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_abort <= 1'b0;
        end else begin
            if (accept_c) begin
                write_q <= bus.req_write;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            bus.req_ready <= (state_d == ST_IDLE);
            bus.rsp_valid <= (state_d == ST_RESP);
            if (state == ST_ACCESS) begin
                bus.rsp_rdata <= (abort_c || write_q) ? '0 : load_c;
                bus.rsp_abort <= abort_c;
            end else if (state_d == ST_IDLE) begin
                bus.rsp_rdata <= '0;
                bus.rsp_abort <= 1'b0;
            end
        end
    end

    // RAM is not reset; a reset before ACCESS leaves the state machine out of ACCESS.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && write_q && !abort_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
            end
        end
    end
endmodule
